// File: rtl/alu_6502_pkg.sv
// Shared types for the 6502 ALU sequencer: ALU bus modes, instruction codes, P bit indices and FSM states.
package alu_6502_pkg;

    typedef enum logic [2:0] {
        ALU_OR  = 3'b000,
        ALU_AND = 3'b001,
        ALU_XOR = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SHL = 3'b100,
        ALU_SHR = 3'b101
    } alu_mode_t;

    // Codes 4'hD..4'hF are illegal and have no enumerator.
    typedef enum logic [3:0] {
        OP_ORA = 4'h0, OP_AND = 4'h1, OP_EOR = 4'h2, OP_ADC = 4'h3,
        OP_SBC = 4'h4, OP_CMP = 4'h5, OP_ASL = 4'h6, OP_LSR = 4'h7,
        OP_ROL = 4'h8, OP_ROR = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
        OP_BIT = 4'hC
    } alu_op_t;

    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_D = 3;
    localparam int P_Z = 1;
    localparam int P_C = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_sequencer_6502_if.sv
// Decoder handshake and ALU bus bundle; slave is the sequencer, master is the environment (decoder + ALU).
interface alu_sequencer_6502_if;
    import alu_6502_pkg::*;

    logic        start;
    logic        ready;
    logic [3:0]  op;
    logic [7:0]  operand_a;
    logic [7:0]  operand_b;
    logic [7:0]  p_in;
    logic        done;
    logic [7:0]  result;
    logic        write_result;
    logic [7:0]  p_out;
    alu_mode_t   alu_mode;
    logic [8:0]  alu_a;
    logic [8:0]  alu_b;
    logic [8:0]  alu_result;

    modport master (
        output start, op, operand_a, operand_b, p_in, alu_result,
        input  ready, done, result, write_result, p_out, alu_mode, alu_a, alu_b
    );

    modport slave (
        input  start, op, operand_a, operand_b, p_in, alu_result,
        output ready, done, result, write_result, p_out, alu_mode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_sequencer_6502_flag.sv
// flag_calc_6502: combinational result/status update from the latched instruction and the ALU pass results.
module flag_calc_6502
    import alu_6502_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] operand_a,
    input  logic [1:0] b_top,
    input  logic [7:0] p_in,
    input  logic       bin_r7,
    input  logic [8:0] final_result,
    output logic [7:0] result,
    output logic [7:0] p_out,
    output logic       write_result
);
    logic b7_eff;
    logic v_flag;
    logic z_flag;

    // Overflow compares against the operand actually fed to the adder, so SBC uses the inverted B bit.
    assign b7_eff = (op == OP_SBC) ? ~b_top[1] : b_top[1];
    assign v_flag = (operand_a[7] == b7_eff) && (bin_r7 != operand_a[7]);
    assign z_flag = (final_result[7:0] == 8'h00);

    always_comb begin
        result       = final_result[7:0];
        p_out        = p_in;
        write_result = 1'b1;
        case (op)
            OP_ORA, OP_AND, OP_EOR, OP_INC, OP_DEC: begin
                p_out[P_N] = final_result[7];
                p_out[P_Z] = z_flag;
            end
            OP_ADC, OP_SBC: begin
                p_out[P_N] = final_result[7];
                p_out[P_Z] = z_flag;
                p_out[P_C] = final_result[8];
                p_out[P_V] = v_flag;
            end
            OP_CMP: begin
                p_out[P_N]   = final_result[7];
                p_out[P_Z]   = z_flag;
                p_out[P_C]   = final_result[8];
                write_result = 1'b0;
            end
            OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
                p_out[P_N] = final_result[7];
                p_out[P_Z] = z_flag;
                p_out[P_C] = final_result[8];
            end
            OP_BIT: begin
                p_out[P_N]   = b_top[1];
                p_out[P_V]   = b_top[0];
                p_out[P_Z]   = z_flag;
                write_result = 1'b0;
            end
            default: begin
                result       = operand_a;
                write_result = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_sequencer_6502.sv
// 6502 ALU sequencer: drives the shared ALU for one instruction and returns result and new P.
// Define DECIMAL_MODE_EN to add the BCD fix passes for ADC/SBC when P.D is set.
module alu_sequencer_6502
    import alu_6502_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    alu_sequencer_6502_if.slave  bus
);
    state_t     state, state_next;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q, p_q;
    logic [7:0] result_q, p_out_q;
    logic       write_q;
    logic [7:0] calc_result, calc_p;
    logic       calc_write;
    logic       bin_r7;
    logic [8:0] final_result;
    logic       dec_op;

`ifdef DECIMAL_MODE_EN
    logic [8:0] bin_q, fix_q;
    logic [7:0] b_eff, lo_corr, hi_corr;
    logic       is_sbc, half_carry, hi_fix, dec_carry;

    assign is_sbc     = (op_q == OP_SBC);
    assign dec_op     = p_q[P_D] && ((op_q == OP_ADC) || is_sbc);
    assign b_eff      = is_sbc ? ~b_q : b_q;
    assign half_carry = a_q[4] ^ b_eff[4] ^ bin_q[4];
    assign hi_fix     = (fix_q[7:0] > 8'h99) || bin_q[8] || fix_q[8];
    assign lo_corr    = is_sbc ? (half_carry ? 8'h00 : 8'hFA)
                               : (((bin_q[3:0] > 4'd9) || half_carry) ? 8'h06 : 8'h00);
    assign hi_corr    = is_sbc ? (bin_q[8] ? 8'h00 : 8'hA0) : (hi_fix ? 8'h60 : 8'h00);
    // SBC keeps the binary borrow; ADC reports carry whenever the high-nibble fix fired.
    assign dec_carry  = is_sbc ? bin_q[8] : hi_fix;
    assign bin_r7       = (state == S_FIX_HI) ? bin_q[7] : bus.alu_result[7];
    assign final_result = (state == S_FIX_HI) ? {dec_carry, bus.alu_result[7:0]} : bus.alu_result;
`else
    assign dec_op       = 1'b0;
    assign bin_r7       = bus.alu_result[7];
    assign final_result = bus.alu_result;
`endif

    always_comb begin
        state_next   = state;
        bus.alu_mode = ALU_OR;
        bus.alu_a    = 'x;
        bus.alu_b    = 'x;
        case (state)
            S_IDLE: if (bus.start) state_next = S_EXEC;
            S_EXEC: begin
                state_next = dec_op ? S_FIX_LO : S_DONE;
                case (op_q)
                    OP_ORA: begin bus.alu_mode = ALU_OR;  bus.alu_a = {1'bx, a_q}; bus.alu_b = {1'bx, b_q}; end
                    OP_AND, OP_BIT: begin
                        bus.alu_mode = ALU_AND; bus.alu_a = {1'bx, a_q}; bus.alu_b = {1'bx, b_q};
                    end
                    OP_EOR: begin bus.alu_mode = ALU_XOR; bus.alu_a = {1'bx, a_q}; bus.alu_b = {1'bx, b_q}; end
                    OP_ADC: begin bus.alu_mode = ALU_ADD; bus.alu_a = {p_q[P_C], a_q}; bus.alu_b = {1'bx, b_q}; end
                    OP_SBC: begin bus.alu_mode = ALU_ADD; bus.alu_a = {p_q[P_C], a_q}; bus.alu_b = {1'bx, ~b_q}; end
                    OP_CMP: begin bus.alu_mode = ALU_ADD; bus.alu_a = {1'b1, a_q}; bus.alu_b = {1'bx, ~b_q}; end
                    OP_INC: begin bus.alu_mode = ALU_ADD; bus.alu_a = {1'b0, a_q}; bus.alu_b = {1'bx, 8'h01}; end
                    OP_DEC: begin bus.alu_mode = ALU_ADD; bus.alu_a = {1'b0, a_q}; bus.alu_b = {1'bx, 8'hFF}; end
                    OP_ASL: begin bus.alu_mode = ALU_SHL; bus.alu_a = {1'b0, a_q}; end
                    OP_ROL: begin bus.alu_mode = ALU_SHL; bus.alu_a = {p_q[P_C], a_q}; end
                    OP_LSR: begin bus.alu_mode = ALU_SHR; bus.alu_a = {1'b0, a_q}; end
                    OP_ROR: begin bus.alu_mode = ALU_SHR; bus.alu_a = {p_q[P_C], a_q}; end
                    default: ;
                endcase
            end
`ifdef DECIMAL_MODE_EN
            S_FIX_LO: begin
                state_next   = S_FIX_HI;
                bus.alu_mode = ALU_ADD;
                bus.alu_a    = {1'b0, bin_q[7:0]};
                bus.alu_b    = {1'bx, lo_corr};
            end
            S_FIX_HI: begin
                state_next   = S_DONE;
                bus.alu_mode = ALU_ADD;
                bus.alu_a    = {1'b0, fix_q[7:0]};
                bus.alu_b    = {1'bx, hi_corr};
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are loaded on the final pass and held until the next instruction completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            result_q <= 8'h00;
            p_out_q  <= 8'h00;
            write_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_DONE) begin
                result_q <= calc_result;
                p_out_q  <= calc_p;
                write_q  <= calc_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.start && (state == S_IDLE)) begin
            op_q <= bus.op;
            a_q  <= bus.operand_a;
            b_q  <= bus.operand_b;
            p_q  <= bus.p_in;
        end
`ifdef DECIMAL_MODE_EN
        if (state == S_EXEC)   bin_q <= bus.alu_result;
        if (state == S_FIX_LO) fix_q <= bus.alu_result;
`endif
    end

    flag_calc_6502 u_flag (
        .op           (op_q),
        .operand_a    (a_q),
        .b_top        (b_q[7:6]),
        .p_in         (p_q),
        .bin_r7       (bin_r7),
        .final_result (final_result),
        .result       (calc_result),
        .p_out        (calc_p),
        .write_result (calc_write)
    );

    assign bus.ready        = (state == S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.result       = result_q;
    assign bus.p_out        = p_out_q;
    assign bus.write_result = write_q;
endmodule

// File: tb/tb_alu_sequencer_6502.sv
// Scoreboard bench for alu_sequencer_6502 with a behavioural ALU on the bus; decimal vectors need DECIMAL_MODE_EN.
module tb_alu_sequencer_6502;
    import alu_6502_pkg::*;

    typedef struct {
        string      name;
        logic [7:0] result;
        logic [7:0] pOut;
        logic       writeResult;
        int         issueCycle;
        int         latency;
    } expect_t;

    logic    clock = 1'b0;
    logic    reset_n;
    int      checks = 0;
    int      errors = 0;
    int      cycleCount = 0;
    int      doneCount = 0;
    expect_t scoreboard[$];
    logic [8:0] aluModel;

    always #5 clock = ~clock;

    alu_sequencer_6502_if bus();

    alu_sequencer_6502 dut (
        .clk     (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        case (bus.alu_mode)
            ALU_OR:  aluModel = {1'b0, bus.alu_a[7:0] | bus.alu_b[7:0]};
            ALU_AND: aluModel = {1'b0, bus.alu_a[7:0] & bus.alu_b[7:0]};
            ALU_XOR: aluModel = {1'b0, bus.alu_a[7:0] ^ bus.alu_b[7:0]};
            ALU_ADD: aluModel = {1'b0, bus.alu_a[7:0]} + {1'b0, bus.alu_b[7:0]} + {8'h00, bus.alu_a[8]};
            ALU_SHL: aluModel = {bus.alu_a[7], bus.alu_a[6:0], bus.alu_a[8]};
            ALU_SHR: aluModel = {bus.alu_a[0], bus.alu_a[8], bus.alu_a[7:1]};
            default: aluModel = 9'h000;
        endcase
    end
    assign bus.alu_result = aluModel;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        expect_t e;
        forever begin
            @(posedge clock);
            cycleCount++;
            #1;
            if (bus.done === 1'b1) begin
                doneCount++;
                if (scoreboard.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput({e.name, "_result"}, {24'h0, bus.result}, {24'h0, e.result});
                    checkOutput({e.name, "_p_out"}, {24'h0, bus.p_out}, {24'h0, e.pOut});
                    checkOutput({e.name, "_write"}, {31'h0, bus.write_result}, {31'h0, e.writeResult});
                    checkOutput({e.name, "_latency"}, cycleCount - e.issueCycle, e.latency);
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] p, input logic [7:0] expResult, input logic [7:0] expP,
                                 input logic expWrite, input int expLatency);
        expect_t e;
        int      startDone;
        int      waited;
        @(negedge clock);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.p_in      = p;
        bus.start     = 1'b1;
        e.name        = name;
        e.result      = expResult;
        e.pOut        = expP;
        e.writeResult = expWrite;
        e.issueCycle  = cycleCount;
        e.latency     = expLatency;
        scoreboard.push_back(e);
        startDone = doneCount;
        @(negedge clock);
        bus.start = 1'b0;
        waited = 0;
        while (doneCount == startDone && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (doneCount == startDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got no done expected done within 20 cycles", name);
            scoreboard.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expect_t e;
        int      startDone;
        bus.start     = 1'b0;
        bus.op        = 4'h0;
        bus.operand_a = 8'h00;
        bus.operand_b = 8'h00;
        bus.p_in      = 8'h00;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_ready", {31'h0, bus.ready}, 32'h1);
        checkOutput("reset_done", {31'h0, bus.done}, 32'h0);
        checkOutput("reset_result", {24'h0, bus.result}, 32'h0);
        checkOutput("reset_p_out", {24'h0, bus.p_out}, 32'h0);
        checkOutput("reset_write", {31'h0, bus.write_result}, 32'h0);
        reset_n = 1'b1;

        // Start held high through the op; the changed operands while busy must not spawn a second op.
        @(negedge clock);
        bus.op = OP_ADC; bus.operand_a = 8'h50; bus.operand_b = 8'h50; bus.p_in = 8'h20; bus.start = 1'b1;
        e.name = "held_adc"; e.result = 8'hA0; e.pOut = 8'hE0; e.writeResult = 1'b1;
        e.issueCycle = cycleCount; e.latency = 2;
        scoreboard.push_back(e);
        startDone = doneCount;
        @(negedge clock);
        checkOutput("held_ready_busy", {31'h0, bus.ready}, 32'h0);
        bus.op = OP_ORA; bus.operand_a = 8'h01; bus.operand_b = 8'h01;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("held_single_done", doneCount - startDone, 32'h1);

        // Reset during EXEC aborts without a done pulse and clears the held outputs.
        bus.op = OP_SBC; bus.operand_a = 8'h00; bus.operand_b = 8'h01; bus.p_in = 8'h21; bus.start = 1'b1;
        startDone = doneCount;
        @(negedge clock);
        bus.start = 1'b0;
        reset_n   = 1'b0;
        @(negedge clock);
        checkOutput("abort_done", {31'h0, bus.done}, 32'h0);
        checkOutput("abort_ready", {31'h0, bus.ready}, 32'h1);
        checkOutput("abort_result", {24'h0, bus.result}, 32'h0);
        checkOutput("abort_p_out", {24'h0, bus.p_out}, 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("abort_no_done", doneCount - startDone, 32'h0);

        applyStimulus("adc_ovf",   OP_ADC, 8'h50, 8'h50, 8'h20, 8'hA0, 8'hE0, 1'b1, 2);
        applyStimulus("adc_carry", OP_ADC, 8'hFF, 8'h01, 8'h20, 8'h00, 8'h23, 1'b1, 2);
        applyStimulus("sbc_borrow",OP_SBC, 8'h00, 8'h01, 8'h21, 8'hFF, 8'hA0, 1'b1, 2);
        applyStimulus("sbc_ovf",   OP_SBC, 8'h80, 8'h01, 8'h21, 8'h7F, 8'h61, 1'b1, 2);
        applyStimulus("cmp_eq",    OP_CMP, 8'h40, 8'h40, 8'h20, 8'h00, 8'h23, 1'b0, 2);
        applyStimulus("ror",       OP_ROR, 8'h01, 8'h00, 8'h21, 8'h80, 8'hA1, 1'b1, 2);
        applyStimulus("asl",       OP_ASL, 8'h80, 8'h55, 8'h20, 8'h00, 8'h23, 1'b1, 2);
        applyStimulus("lsr",       OP_LSR, 8'h01, 8'hFF, 8'h3C, 8'h00, 8'h3F, 1'b1, 2);
        applyStimulus("rol",       OP_ROL, 8'h40, 8'h00, 8'h21, 8'h81, 8'hA0, 1'b1, 2);
        applyStimulus("ora",       OP_ORA, 8'h0F, 8'hF0, 8'h20, 8'hFF, 8'hA0, 1'b1, 2);
        applyStimulus("and",       OP_AND, 8'hCC, 8'h0F, 8'hC3, 8'h0C, 8'h41, 1'b1, 2);
        applyStimulus("eor",       OP_EOR, 8'hAA, 8'hAA, 8'h80, 8'h00, 8'h02, 1'b1, 2);
        applyStimulus("inc_wrap",  OP_INC, 8'hFF, 8'h33, 8'h21, 8'h00, 8'h23, 1'b1, 2);
        applyStimulus("dec_wrap",  OP_DEC, 8'h00, 8'h33, 8'h20, 8'hFF, 8'hA0, 1'b1, 2);
        applyStimulus("bit",       OP_BIT, 8'h0F, 8'hC0, 8'h20, 8'h00, 8'hE2, 1'b0, 2);
        applyStimulus("illegal",   4'hE,   8'h37, 8'h99, 8'hC5, 8'h37, 8'hC5, 1'b0, 2);
`ifdef DECIMAL_MODE_EN
        applyStimulus("adc_bcd",   OP_ADC, 8'h58, 8'h46, 8'h29, 8'h05, 8'h69, 1'b1, 4);
        applyStimulus("sbc_bcd",   OP_SBC, 8'h12, 8'h21, 8'h29, 8'h91, 8'hA8, 1'b1, 4);
`else
        applyStimulus("adc_dflag", OP_ADC, 8'h58, 8'h46, 8'h29, 8'h9F, 8'hE8, 1'b1, 2);
        applyStimulus("sbc_dflag", OP_SBC, 8'h12, 8'h21, 8'h29, 8'hF1, 8'hA8, 1'b1, 2);
`endif
        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", scoreboard.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
